bin_bcd_seq: RTL and testbench
==============================

# bin_bcd_seq

Sequential binary-to-BCD converter: the reverse path of the lab's BCD-to-binary block. Accepts an unsigned binary word on a start handshake, runs a shift-and-add-3 (double-dabble) iteration one bit per clock, and presents packed BCD digits with a one-cycle done pulse. Its default width pairs with the 8-bit BCD / 7-bit binary converter, so the two round-trip in a bench. It sits between datapath results and display or readout logic.

## Interface
- WIDTH, 7: binary input width (unsigned).
- DIGITS, 3: number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH - 1; elaboration-time check fails otherwise.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
- start  input  1  request; accepted only on an edge where ready=1.
- bin  input  WIDTH  value to convert; sampled only on the accepting edge.
- ready  output  1  high when a new start will be accepted (states IDLE and DONE).
- done  output  1  one-cycle pulse: bcd holds a fresh result.
- bcd  output  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0]; held until overwritten by the next completed conversion.

## Operation
- States: IDLE, SHIFT, DONE.
- Reset (rst_n=0 at an edge): state=IDLE, bcd=0, done=0, ready=1, internal shift/count registers cleared. Reset overrides every other input, including mid-conversion; a partial result is discarded, never published.
- IDLE: start=1 loads bin into binary shift register, clears BCD accumulator, count=WIDTH, goes to SHIFT. start=0 stays put.
- SHIFT, each edge:
  - Every accumulator digit >=5 gets +3 (4-bit add; no carry out of the digit by construction).
  - {accumulator, binary shift reg} shifts left 1; count decrements.
  - On the edge where count goes 1->0: write the shifted accumulator to bcd, set done=1, go to DONE.
- DONE: done=1 for exactly this cycle. start=1 here is accepted like in IDLE (load, go to SHIFT) for back-to-back conversions; otherwise go to IDLE. done drops on the next edge either way.
- start during SHIFT is ignored, not queued; bin changes during SHIFT have no effect.
- bcd digits are always 0-9. Unused upper digits are 0.

## Timing
- Accept at edge E0; shifts on edges E1..E_WIDTH; bcd and done valid in the cycle after E_WIDTH. Latency is WIDTH+1 edges from accept to done (8 at default).
- ready is low for cycles after E0 through E_WIDTH, high in the done cycle.
- Max throughput is one conversion per WIDTH+1 cycles with start held high.
- All outputs are registered. The add-3 correction and shift are a single combinational stage per edge.

## Structure
- Package bcd_pkg: DIGIT_W=4, ADD3_THRESH=5, ADD3_VAL=3, state enum {IDLE, SHIFT, DONE}. It is shared with the BCD-to-binary block's future sequential version.
- Sub-module bcd_add3: a combinational 4-bit digit correction (in>=5 ? in+3 : in), instantiated DIGITS times with a generate loop.
- The counter width is clog2(WIDTH+1).

## Test plan
- bin=97, start pulse -> done exactly 8 cycles after the accept edge, bcd=0000_1001_0111; feed it to the BCD-to-binary block -> 97.
- bin=58 -> bcd=0000_0101_1000. bin=12 -> 0000_0001_0010. bin=0 -> 0000_0000_0000. bin=127 -> 0001_0010_0111.
- Exhaustive 0..127 with start held high -> a done every 8 cycles, each bcd equals the decimal digits of the input, no digit >9.
- Start bin=97, then pulse start with bin=58 during SHIFT -> ignored; result 97, ready=0 throughout SHIFT.
- Start bin=127, drive rst_n low at the 4th shift edge -> next cycle ready=1, done=0, bcd=0; a following start with bin=12 -> 0000_0001_0010.
- Back-to-back: start high in the DONE cycle with new bin=58 -> first done shows 97, second done 8 cycles later shows 58, no idle cycle between them.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants and types for the BCD conversion blocks.
//   DIGIT_W      width of one packed BCD digit
//   ADD3_THRESH  digit value at or above which double-dabble adds a correction
//   ADD3_VAL     correction added to such a digit before each left shift
//   state_t      conversion FSM states
//   pow10()      constant helper used for elaboration-time range checks
package bcd_pkg;

    localparam int DIGIT_W     = 4;
    localparam int ADD3_THRESH = 5;
    localparam int ADD3_VAL    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: combinational double-dabble digit correction.
// Ports:
//   i_digit  in   4  current BCD digit
//   o_digit  out  4  i_digit + 3 when i_digit >= 5, else i_digit
// Inputs 0..9 map to at most 12, so the result never overflows 4 bits.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= DIGIT_W'(ADD3_THRESH)) ? (i_digit + DIGIT_W'(ADD3_VAL))
                                                        : i_digit;

endmodule

// File: rtl/bin_bcd_seq.sv
// bin_bcd_seq: sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Ports:
//   clk          in   1         clock, rising edge
//   rst_n        in   1         synchronous active-low reset
//   start        in   1         request; taken on an edge where ready=1
//   bin          in   WIDTH     unsigned value, sampled on the accepting edge
//   ready        out  1         high in IDLE and DONE
//   done         out  1         one-cycle pulse, bcd holds a fresh result
//   bcd          out  4*DIGITS  packed BCD, units digit in [3:0]; held until next result
//   o_dbg_state  out  state_t   current FSM state, for observation only
// Handshake: start is a request that is consumed on any rising edge where
// ready=1 and is ignored otherwise (not queued); done is a single-cycle
// qualifier for bcd with no back-pressure.
module bin_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WIDTH-1:0]       bin,
    output logic                   ready,
    output logic                   done,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output state_t                 o_dbg_state
);

    localparam int ACC_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    // The largest input must fit in DIGITS decimal digits.
    if (pow10(DIGITS) <= ((longint'(1) << WIDTH) - 1)) begin : g_range_check
        $error("bin_bcd_seq: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
    end

    state_t             r_state;
    logic [WIDTH-1:0]   r_bin;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_bcd;
    logic               r_done;
    logic               r_ready;

    logic [ACC_W-1:0]       w_acc_adj;
    logic [ACC_W+WIDTH-1:0] w_shift;
    logic [ACC_W+WIDTH-1:0] w_shift_next;
    logic [ACC_W-1:0]       w_acc_next;
    logic [WIDTH-1:0]       w_bin_next;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_digit (r_acc[g*DIGIT_W +: DIGIT_W]),
            .o_digit (w_acc_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Correct first, then shift the combined {accumulator, binary} word left.
    assign w_shift      = {w_acc_adj, r_bin};
    assign w_shift_next = w_shift << 1;
    assign w_acc_next   = w_shift_next[ACC_W+WIDTH-1:WIDTH];
    assign w_bin_next   = w_shift_next[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_bin   <= bin;
                        r_acc   <= '0;
                        r_cnt   <= CNT_W'(WIDTH);
                        r_ready <= 1'b0;
                        r_state <= SHIFT;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_acc <= w_acc_next;
                    r_bin <= w_bin_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Last bit: publish the shifted accumulator directly.
                    if (r_cnt == CNT_W'(1)) begin
                        r_bcd   <= w_acc_next;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready       = r_ready;
    assign done        = r_done;
    assign bcd         = r_bcd;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Self-checking bench for bin_bcd_seq (WIDTH=7, DIGITS=3).
module tb_bin_bcd_seq;
    import bcd_pkg::*;

    localparam int WIDTH  = 7;
    localparam int DIGITS = 3;
    localparam int BW     = 4 * DIGITS;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [WIDTH-1:0] bin;
    logic            ready;
    logic            done;
    logic [BW-1:0]   bcd;
    state_t          dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [BW-1:0] exp_q[$];
    int            exp_cyc_q[$];

    logic [WIDTH-1:0] stream_vals[$];
    logic [BW-1:0]    stream_exp[$];

    bin_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bin         (bin),
        .ready       (ready),
        .done        (done),
        .bcd         (bcd),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    function automatic logic [BW-1:0] dec_bcd(input int v);
        logic [BW-1:0] r;
        r = '0;
        r[3:0]  = 4'(v % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[11:8] = 4'((v / 100) % 10);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    // done is seen in the cycle after edge accept+WIDTH, i.e. WIDTH+1 cycles
    // counting the cycle in which start was presented.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst_n && done) begin
            check("done_pulse_width", 32'(prev_done), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got bcd %0h with no pending conversion", bcd);
            end else begin
                logic [BW-1:0] e;
                int ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("bcd_value", 32'(bcd), 32'(e));
                check("done_latency", 32'(cyc), 32'(ec));
                for (int d = 0; d < DIGITS; d++) begin
                    check("digit_range", 32'(bcd[d*4 +: 4] <= 4'd9), 32'd1);
                end
            end
        end
        prev_done = done;
    end

    // ---------------- drivers ----------------
    task automatic issue(input logic [WIDTH-1:0] v, input logic [BW-1:0] e, input bit track);
        int waited;
        waited = 0;
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        while (!ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready %0d expected 1", ready);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        if (track) begin
            exp_q.push_back(e);
            exp_cyc_q.push_back(cyc + WIDTH);
        end
    endtask

    // start held high across a list of values; each new bin is presented
    // right after the previous accept, so accepts should be WIDTH+1 apart.
    task automatic run_stream();
        int waited;
        int last_acc;
        last_acc = -1;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < stream_vals.size(); i++) begin
            bin = stream_vals[i];
            waited = 0;
            while (!ready && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            if (!ready) begin
                checks++;
                errors++;
                $display("FAIL stream_ready_timeout: ready %0d expected 1", ready);
                break;
            end
            @(posedge clk);
            #1;
            exp_q.push_back(stream_exp[i]);
            exp_cyc_q.push_back(cyc + WIDTH);
            if (last_acc >= 0) check("accept_spacing", 32'(cyc - last_acc), 32'(WIDTH + 1));
            last_acc = cyc;
        end
        start = 1'b0;
        stream_vals.delete();
        stream_exp.delete();
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done",  32'(done),  32'd0);
        check("reset_bcd",   32'(bcd),   32'd0);
        rst_n = 1'b1;

        // Directed single conversions.
        issue(7'd97,  12'h097, 1'b1); drain();
        issue(7'd58,  12'h058, 1'b1); drain();
        issue(7'd12,  12'h012, 1'b1); drain();
        issue(7'd0,   12'h000, 1'b1); drain();
        issue(7'd127, 12'h127, 1'b1); drain();

        // start pulsed during SHIFT is ignored; ready stays low while shifting.
        issue(7'd97, 12'h097, 1'b1);
        @(negedge clk);
        check("ready_low_shift", 32'(ready), 32'd0);
        start = 1'b1;
        bin   = 7'd58;
        @(negedge clk);
        check("ready_low_shift", 32'(ready), 32'd0);
        start = 1'b0;
        bin   = 7'd0;
        repeat (3) begin
            @(negedge clk);
            check("ready_low_shift", 32'(ready), 32'd0);
        end
        drain();

        // Reset in the middle of a conversion discards the partial result.
        issue(7'd127, 12'h000, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_ready", 32'(ready), 32'd1);
        check("midreset_done",  32'(done),  32'd0);
        check("midreset_bcd",   32'(bcd),   32'd0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(7'd12, 12'h012, 1'b1); drain();

        // Back-to-back: second start accepted in the DONE cycle.
        stream_vals.push_back(7'd97); stream_exp.push_back(12'h097);
        stream_vals.push_back(7'd58); stream_exp.push_back(12'h058);
        run_stream();
        drain();

        // Exhaustive sweep with start held high.
        for (int v = 0; v < 128; v++) begin
            stream_vals.push_back(7'(v));
            stream_exp.push_back(dec_bcd(v));
        end
        run_stream();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
